// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// default source count and the fixed-priority encoder.
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_type;

  localparam int N_SRC_DEFAULT = 4;
  localparam int PRIO_W        = 16;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic int prio_enc(input logic [PRIO_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_sync.sv
// One interrupt line: multi-flop synchronizer followed by a rising-edge
// detector producing a single-cycle pulse per low-to-high transition.
module intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: synchronized edge capture into pending
// bits, fixed-priority selection and a non-nesting request/service handshake.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_SRC-1:0] src_in,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  input  logic             int_taken,
  input  logic             mret_exec,
  output logic             intr,
  output logic [ID_W-1:0]  cause_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] en_q,
  output logic             busy
);

  logic [N_SRC-1:0]  edge_vec;
  logic [N_SRC-1:0]  clr_vec;
  logic [N_SRC-1:0]  pending_reg;
  logic [N_SRC-1:0]  en_reg;
  logic [N_SRC-1:0]  eligible;
  logic [PRIO_W-1:0] elig_ext;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cause_reg;
  logic [ID_W-1:0]   cause_next;
  state_type         state_reg;
  state_type         state_next;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      intr_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .RST     (RST),
        .async_in(src_in[gi]),
        .rise    (edge_vec[gi])
      );
    end
  endgenerate

  // Enable only gates arbitration; disabled sources still collect pending.
  assign eligible = pending_reg & en_reg;

  always_comb begin
    elig_ext                = '0;
    elig_ext[N_SRC-1:0]     = eligible;
    winner                  = ID_W'(prio_enc(elig_ext));
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    clr_vec    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (|eligible) begin
          cause_next = winner;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_taken) begin
          clr_vec[cause_reg] = 1'b1;
          state_next         = ST_SERVICE;
        end else if (!en_reg[cause_reg]) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (mret_exec) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A new edge on a bit being cleared this cycle wins, so the event survives.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      cause_reg   <= '0;
      pending_reg <= '0;
      en_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cause_reg   <= cause_next;
      pending_reg <= (pending_reg & ~clr_vec) | edge_vec;
      if (en_we) en_reg <= en_wdata;
    end
  end

  assign intr     = (state_reg == ST_REQ);
  assign busy     = (state_reg == ST_SERVICE);
  assign cause_id = cause_reg;
  assign pending  = pending_reg;
  assign en_q     = en_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with fixed expectations followed by
// randomized traffic checked against a cycle-level behavioural model.
module tb_intr_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] src_in = '0;
  logic       en_we = 1'b0;
  logic [3:0] en_wdata = '0;
  logic       int_taken = 1'b0;
  logic       mret_exec = 1'b0;
  logic       intr;
  logic [1:0] cause_id;
  logic [3:0] pending;
  logic [3:0] en_q;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit [3:0] m_pend, m_en;
  bit       m_req, m_busy;
  bit [1:0] m_cause;
  bit [3:0] hist [0:S];

  intr_ctrl #(.N_SRC(4), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .RST      (RST),
    .src_in   (src_in),
    .en_we    (en_we),
    .en_wdata (en_wdata),
    .int_taken(int_taken),
    .mret_exec(mret_exec),
    .intr     (intr),
    .cause_id (cause_id),
    .pending  (pending),
    .en_q     (en_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock: compute model from pre-edge inputs, commit after edge.
  task automatic cycle();
    bit [3:0] edg, clr, elig, n_pend, n_en;
    bit       n_req, n_busy;
    bit [1:0] n_cause;
    if (RST) begin
      n_pend = '0; n_en = '0; n_req = 0; n_busy = 0; n_cause = '0;
      for (int j = 0; j <= S; j++) hist[j] = '0;
    end else begin
      edg  = hist[S-1] & ~hist[S];
      clr  = '0;
      if (m_req && int_taken) clr[m_cause] = 1'b1;
      elig   = m_pend & m_en;
      n_pend = (m_pend & ~clr) | edg;
      n_en   = en_we ? en_wdata : m_en;
      n_req = m_req; n_busy = m_busy; n_cause = m_cause;
      if (m_req) begin
        if (int_taken) begin n_req = 0; n_busy = 1; end
        else if (!m_en[m_cause]) n_req = 0;
      end else if (m_busy) begin
        if (mret_exec) n_busy = 0;
      end else if (elig != 0) begin
        for (int i = 3; i >= 0; i--) if (elig[i]) n_cause = 2'(i);
        n_req = 1;
      end
      for (int j = S; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = src_in;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_en = n_en; m_req = n_req; m_busy = n_busy; m_cause = n_cause;
  endtask

  task automatic pulse(input logic [3:0] mask);
    src_in = mask; cycle(); src_in = '0;
  endtask

  task automatic write_en(input logic [3:0] mask);
    en_we = 1'b1; en_wdata = mask; cycle(); en_we = 1'b0;
  endtask

  task automatic take();
    int_taken = 1'b1; cycle(); int_taken = 1'b0;
  endtask

  task automatic mret();
    mret_exec = 1'b1; cycle(); mret_exec = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; cycle(); cycle(); RST = 1'b0;
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", intr); end
    total++; if (cause_id !== 2'd0) begin bad++; $display("FAIL reset_cause: got %0d want 0", cause_id); end
    total++; if (pending !== 4'b0) begin bad++; $display("FAIL reset_pending: got %b want 0000", pending); end
    total++; if (en_q !== 4'b0) begin bad++; $display("FAIL reset_en: got %b want 0000", en_q); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    $display("reset: outputs intr=%b busy=%b pending=%b", intr, busy, pending);
  endtask

  task automatic test_single();
    write_en(4'b1111);
    pulse(4'b0100); cycle(); cycle();
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pending: got %b want 0100", pending); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL single_early_intr: got %b want 0", intr); end
    cycle();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL single_intr: got %b want 1", intr); end
    total++; if (cause_id !== 2'd2) begin bad++; $display("FAIL single_cause: got %0d want 2", cause_id); end
    take();
    total++; if ({intr, busy} !== 2'b01) begin bad++; $display("FAIL single_taken: got intr/busy=%b want 01", {intr, busy}); end
    total++; if (pending !== 4'b0) begin bad++; $display("FAIL single_clr: got %b want 0000", pending); end
    mret();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_mret: got busy=%b want 0", busy); end
    $display("single: served cause 2");
  endtask

  task automatic test_priority();
    pulse(4'b1010); cycle(); cycle();
    total++; if (pending !== 4'b1010) begin bad++; $display("FAIL prio_pending: got %b want 1010", pending); end
    cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd1) begin bad++; $display("FAIL prio_first: got intr=%b cause=%0d want 1/1", intr, cause_id); end
    take();
    total++; if (pending !== 4'b1000) begin bad++; $display("FAIL prio_left: got %b want 1000", pending); end
    mret();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL prio_gap: got intr=%b want 0", intr); end
    cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd3) begin bad++; $display("FAIL prio_second: got intr=%b cause=%0d want 1/3", intr, cause_id); end
    take(); mret();
    $display("priority: served cause 1 then 3");
  endtask

  task automatic test_masked();
    write_en(4'b0001);
    pulse(4'b0100); cycle(); cycle(); cycle();
    total++; if (pending[2] !== 1'b1) begin bad++; $display("FAIL mask_pending: got %b want 1", pending[2]); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL mask_intr: got %b want 0", intr); end
    write_en(4'b0100);
    cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd2) begin bad++; $display("FAIL mask_enable: got intr=%b cause=%0d want 1/2", intr, cause_id); end
    take(); mret();
    $display("masked: cause 2 released by enable");
  endtask

  task automatic test_disable_req();
    write_en(4'b1111);
    pulse(4'b0001); cycle(); cycle(); cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd0) begin bad++; $display("FAIL dis_req: got intr=%b cause=%0d want 1/0", intr, cause_id); end
    write_en(4'b0000);
    cycle();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL dis_drop: got intr=%b want 0", intr); end
    total++; if (pending[0] !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL dis_keep: got pend0=%b busy=%b want 1/0", pending[0], busy); end
    $display("disable: request withdrawn, pending kept");
  endtask

  task automatic test_collision();
    write_en(4'b1111); cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd0) begin bad++; $display("FAIL coll_req: got intr=%b cause=%0d want 1/0", intr, cause_id); end
    pulse(4'b0001); cycle();
    take();
    total++; if (busy !== 1'b1 || pending[0] !== 1'b1) begin bad++; $display("FAIL coll_setwins: got busy=%b pend0=%b want 1/1", busy, pending[0]); end
    mret(); cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd0) begin bad++; $display("FAIL coll_rereq: got intr=%b cause=%0d want 1/0", intr, cause_id); end
    take(); mret();
    total++; if (pending !== 4'b0) begin bad++; $display("FAIL coll_clean: got %b want 0000", pending); end
    $display("collision: edge during int_taken kept");
  endtask

  task automatic test_reset_service();
    pulse(4'b0001); cycle(); cycle(); cycle(); take();
    pulse(4'b1010); cycle(); cycle();
    total++; if (pending !== 4'b1010 || busy !== 1'b1) begin bad++; $display("FAIL rsv_setup: got pend=%b busy=%b want 1010/1", pending, busy); end
    RST = 1'b1; cycle(); RST = 1'b0;
    total++; if ({intr, busy, cause_id, pending, en_q} !== 12'b0) begin bad++; $display("FAIL rsv_clear: got intr=%b busy=%b cause=%0d pend=%b en=%b want all 0", intr, busy, cause_id, pending, en_q); end
    write_en(4'b1111); cycle(); cycle(); cycle();
    total++; if (intr !== 1'b0 || pending !== 4'b0) begin bad++; $display("FAIL rsv_quiet: got intr=%b pend=%b want 0/0000", intr, pending); end
    src_in = 4'b1000;
    RST = 1'b1; cycle(); cycle(); RST = 1'b0;
    write_en(4'b1000); cycle(); cycle(); cycle();
    total++; if (intr !== 1'b1 || cause_id !== 2'd3) begin bad++; $display("FAIL rsv_held_req: got intr=%b cause=%0d want 1/3", intr, cause_id); end
    take(); mret();
    for (int i = 0; i < 5; i++) cycle();
    total++; if (intr !== 1'b0 || pending !== 4'b0) begin bad++; $display("FAIL rsv_held_once: got intr=%b pend=%b want 0/0000", intr, pending); end
    src_in = '0;
    $display("reset_service: cleared, held line gave one event");
  endtask

  task automatic test_random();
    int served = 0;
    for (int n = 0; n < 600; n++) begin
      bit was_busy;
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) src_in[b] = ~src_in[b];
      en_we     = ($urandom_range(15) == 0);
      en_wdata  = 4'($urandom) | 4'($urandom);
      int_taken = m_req ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0);
      mret_exec = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
      RST       = ($urandom_range(199) == 0);
      was_busy  = m_busy;
      cycle();
      total++; if (intr !== m_req) begin bad++; $display("FAIL rnd_intr @%0d: got %b want %b", n, intr, m_req); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", n, busy, m_busy); end
      total++; if (cause_id !== m_cause) begin bad++; $display("FAIL rnd_cause @%0d: got %0d want %0d", n, cause_id, m_cause); end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pending @%0d: got %b want %b", n, pending, m_pend); end
      total++; if (en_q !== m_en) begin bad++; $display("FAIL rnd_en @%0d: got %b want %b", n, en_q, m_en); end
      if (m_busy && !was_busy) begin
        served++;
        $display("random: service #%0d cause=%0d pending=%b", served, m_cause, m_pend);
      end
    end
    en_we = 0; int_taken = 0; mret_exec = 0; RST = 0; src_in = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_disable_req();
    test_collision();
    test_reset_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
